// File: rtl/reduce_tree_pipe_pkg.sv
// Shared types and helpers for the pipelined reduction tree.
// Mode encodings, identity element and level-width arithmetic.
package reduce_tree_pipe_pkg;

    typedef enum logic [1:0] {
        RED_OR  = 2'b00,
        RED_AND = 2'b01,
        RED_XOR = 2'b10,
        RED_NOR = 2'b11
    } red_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of the vector after k pairwise levels
    function automatic int lvl_w(input int w, input int k);
        int r;
        r = w;
        for (int i = 0; i < k; i++) r = (r + 1) / 2;
        return r;
    endfunction

    function automatic logic identity_bit(input red_mode_e m);
        return (m == RED_AND);
    endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Request/result handshake bundle for reduce_tree_pipe.
// master drives requests and consumes results; slave is the block.
interface reduce_tree_pipe_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_bit
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_bit
    );
endinterface

// File: rtl/reduce_tree_pipe_level.sv
// One tree level: pairwise combine for the carried mode, then register
// data, valid and mode together under the global advance enable.
module reduce_level
    import reduce_tree_pipe_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = (IN_W + 1) / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic [IN_W-1:0]  in_dat,
    input  logic             in_vld,
    input  red_mode_e        in_mode,
    output logic [OUT_W-1:0] out_dat,
    output logic             out_vld,
    output red_mode_e        out_mode
);

    logic [2*OUT_W-1:0] pad;
    logic [OUT_W-1:0]   comb;

    logic [OUT_W-1:0] dat_d, dat_q;
    logic             vld_d, vld_q;
    red_mode_e        mode_d, mode_q;

    // Odd tail pairs with the identity, so it passes through unchanged
    always_comb begin
        pad = {(2*OUT_W){identity_bit(in_mode)}};
        pad[IN_W-1:0] = in_dat;
        comb = '0;
        for (int i = 0; i < OUT_W; i++) begin
            unique case (in_mode)
                RED_AND: comb[i] = pad[2*i] & pad[2*i+1];
                RED_XOR: comb[i] = pad[2*i] ^ pad[2*i+1];
                default: comb[i] = pad[2*i] | pad[2*i+1];
            endcase
        end
    end

    always_comb begin
        dat_d  = dat_q;
        vld_d  = vld_q;
        mode_d = mode_q;
        if (adv) begin
            dat_d  = comb;
            vld_d  = in_vld;
            mode_d = in_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_q  <= '0;
            vld_q  <= 1'b0;
            mode_q <= RED_OR;
        end else begin
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    assign out_dat  = dat_q;
    assign out_vld  = vld_q;
    assign out_mode = mode_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input OR/AND/XOR/NOR reduction, one tree level per stage.
// All stages share one advance enable; NOR is an OR tree inverted at the end.
module reduce_tree_pipe
    import reduce_tree_pipe_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic              clk,
    input  logic              reset,
    reduce_tree_pipe_if.slave bus
);

    localparam int LEVELS = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1;

    logic      adv;
    logic      last_d;
    logic      last_v;
    red_mode_e last_m;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IW = lvl_w(WIDTH, k);
        localparam int OW = lvl_w(WIDTH, k + 1);

        logic [IW-1:0] d_in;
        logic          v_in;
        red_mode_e     m_in;
        logic [OW-1:0] d_out;
        logic          v_out;
        red_mode_e     m_out;

        if (k == 0) begin : g_src
            assign d_in = bus.in_data;
            assign v_in = bus.in_valid;
            assign m_in = red_mode_e'(bus.in_mode);
        end else begin : g_chain
            assign d_in = g_lvl[k-1].d_out;
            assign v_in = g_lvl[k-1].v_out;
            assign m_in = g_lvl[k-1].m_out;
        end

        reduce_level #(
            .IN_W (IW)
        ) u_lvl (
            .clk      (clk),
            .reset    (reset),
            .adv      (adv),
            .in_dat   (d_in),
            .in_vld   (v_in),
            .in_mode  (m_in),
            .out_dat  (d_out),
            .out_vld  (v_out),
            .out_mode (m_out)
        );
    end

    assign last_d = g_lvl[LEVELS-1].d_out[0];
    assign last_v = g_lvl[LEVELS-1].v_out;
    assign last_m = g_lvl[LEVELS-1].m_out;

    // Whole pipe freezes only when a held result is refused
    assign adv = ~last_v | bus.out_ready;

    assign bus.in_ready  = adv;
    assign bus.out_valid = last_v;
    assign bus.out_bit   = last_d ^ (last_m == RED_NOR);

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench for reduce_tree_pipe at WIDTH 7, 32 and 1.
// Drivers push expected bits and due cycles; monitors pop on every transfer.
module tb_reduce_tree_pipe;

    typedef struct {
        bit b;
        int due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    exp_t q7[$];
    exp_t q32[$];
    exp_t q1[$];

    reduce_tree_pipe_if #(.WIDTH(7))  if7 ();
    reduce_tree_pipe_if #(.WIDTH(32)) if32 ();
    reduce_tree_pipe_if #(.WIDTH(1))  if1 ();

    reduce_tree_pipe #(.WIDTH(7)) u7 (
        .clk   (clk),
        .reset (reset),
        .bus   (if7)
    );

    reduce_tree_pipe #(.WIDTH(32)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    reduce_tree_pipe #(.WIDTH(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic int lat(input int sel);
        case (sel)
            0:       return 3;
            1:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic void pop_cmp(input int sel, input logic b);
        exp_t e;
        int   n;
        case (sel)
            0:       n = q7.size();
            1:       n = q32.size();
            default: n = q1.size();
        endcase
        if (n == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out dut%0d: got bit %0b, required no output",
                     sel, b);
            return;
        end
        case (sel)
            0:       e = q7.pop_front();
            1:       e = q32.pop_front();
            default: e = q1.pop_front();
        endcase
        chk($sformatf("out_bit dut%0d", sel), {31'b0, b}, {31'b0, e.b});
        if (e.due >= 0)
            chk($sformatf("latency dut%0d", sel), cyc, e.due);
    endfunction

    always @(negedge clk)
        if (!reset && if7.out_valid && if7.out_ready) pop_cmp(0, if7.out_bit);
    always @(negedge clk)
        if (!reset && if32.out_valid && if32.out_ready) pop_cmp(1, if32.out_bit);
    always @(negedge clk)
        if (!reset && if1.out_valid && if1.out_ready) pop_cmp(2, if1.out_bit);

    task automatic set_in(input int sel, input logic v,
                          input logic [31:0] d, input logic [1:0] m);
        case (sel)
            0: begin
                if7.in_valid = v;
                if7.in_data  = d[6:0];
                if7.in_mode  = m;
            end
            1: begin
                if32.in_valid = v;
                if32.in_data  = d;
                if32.in_mode  = m;
            end
            default: begin
                if1.in_valid = v;
                if1.in_data  = d[0];
                if1.in_mode  = m;
            end
        endcase
    endtask

    function automatic logic get_rdy(input int sel);
        case (sel)
            0:       return if7.in_ready;
            1:       return if32.in_ready;
            default: return if1.in_ready;
        endcase
    endfunction

    // Call just after a rising edge; returns just after the accepting edge
    task automatic send(input int sel, input logic [31:0] d,
                        input logic [1:0] m, input bit e, input bit tchk);
        bit   ok;
        exp_t x;
        ok = 0;
        set_in(sel, 1'b1, d, m);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (get_rdy(sel)) begin
                ok    = 1;
                x.b   = e;
                x.due = tchk ? cyc + lat(sel) : -1;
                case (sel)
                    0:       q7.push_back(x);
                    1:       q32.push_back(x);
                    default: q1.push_back(x);
                endcase
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        set_in(sel, 1'b0, 32'h0, 2'b00);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", sel);
        end
    endtask

    task automatic wait_empty(input int max_cyc);
        bit done;
        done = 0;
        for (int n = 0; n < max_cyc; n++) begin
            if (q7.size() == 0 && q32.size() == 0 && q1.size() == 0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d, required 0",
                     q7.size() + q32.size() + q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_in(0, 1'b0, 32'h0, 2'b00);
        set_in(1, 1'b0, 32'h0, 2'b00);
        set_in(2, 1'b0, 32'h0, 2'b00);
        if7.out_ready  = 1'b1;
        if32.out_ready = 1'b1;
        if1.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid w7", {31'b0, if7.out_valid}, 0);
        chk("rst out_bit w7", {31'b0, if7.out_bit}, 0);
        chk("rst out_valid w32", {31'b0, if32.out_valid}, 0);
        chk("rst out_bit w32", {31'b0, if32.out_bit}, 0);
        chk("rst out_valid w1", {31'b0, if1.out_valid}, 0);
        chk("rst out_bit w1", {31'b0, if1.out_bit}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready w7", {31'b0, if7.in_ready}, 1);
        chk("post-rst in_ready w32", {31'b0, if32.in_ready}, 1);
        chk("post-rst in_ready w1", {31'b0, if1.in_ready}, 1);
        @(posedge clk);
        #1;

        // WIDTH=7 OR / AND / XOR / NOR, latency 3
        send(0, 32'h40, 2'b00, 1'b1, 1'b1);
        send(0, 32'h00, 2'b00, 1'b0, 1'b1);
        send(0, 32'h01, 2'b00, 1'b1, 1'b1);
        send(0, 32'h7F, 2'b01, 1'b1, 1'b1);
        send(0, 32'h7E, 2'b01, 1'b0, 1'b1);
        send(0, 32'h7F, 2'b10, 1'b1, 1'b1);
        send(0, 32'h41, 2'b10, 1'b0, 1'b1);
        send(0, 32'h00, 2'b11, 1'b1, 1'b1);
        send(0, 32'h20, 2'b11, 1'b0, 1'b1);
        wait_empty(20);

        // WIDTH=32 mixed modes back to back, latency 5
        send(1, 32'h0000_0001, 2'b10, 1'b1, 1'b1);
        send(1, 32'h0000_0000, 2'b11, 1'b1, 1'b1);
        send(1, 32'h0000_0000, 2'b00, 1'b0, 1'b1);
        send(1, 32'hFFFF_FFFF, 2'b01, 1'b1, 1'b1);
        send(1, 32'hFFFF_FFFE, 2'b01, 1'b0, 1'b1);
        send(1, 32'h8000_0001, 2'b10, 1'b0, 1'b1);
        wait_empty(20);

        // WIDTH=1, accept and drain every cycle
        send(2, 32'h1, 2'b11, 1'b0, 1'b1);
        send(2, 32'h0, 2'b11, 1'b1, 1'b1);
        send(2, 32'h1, 2'b00, 1'b1, 1'b1);
        send(2, 32'h0, 2'b01, 1'b0, 1'b1);
        send(2, 32'h1, 2'b10, 1'b1, 1'b1);
        wait_empty(20);

        // Backpressure on WIDTH=7
        if7.out_ready = 1'b0;
        send(0, 32'h07, 2'b10, 1'b1, 1'b0);
        send(0, 32'h3F, 2'b01, 1'b0, 1'b0);
        send(0, 32'h00, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall out_valid", {31'b0, if7.out_valid}, 1);
            chk("stall out_bit", {31'b0, if7.out_bit}, 1);
            chk("stall in_ready", {31'b0, if7.in_ready}, 0);
            @(posedge clk);
            #1;
        end
        if7.out_ready = 1'b1;
        wait_empty(20);
        repeat (4) @(negedge clk);
        chk("stall drained", q7.size(), 0);
        @(posedge clk);
        #1;

        // Async reset with three requests in flight on WIDTH=7
        if7.out_ready = 1'b0;
        send(0, 32'h10, 2'b00, 1'b1, 1'b0);
        send(0, 32'h7F, 2'b11, 1'b0, 1'b0);
        send(0, 32'h55, 2'b10, 1'b0, 1'b0);
        #2;
        chk("pre-rst out_valid", {31'b0, if7.out_valid}, 1);
        reset = 1'b1;
        #1;
        chk("async rst out_valid", {31'b0, if7.out_valid}, 0);
        chk("async rst out_bit", {31'b0, if7.out_bit}, 0);
        q7.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        if7.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no stale out_valid", {31'b0, if7.out_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(0, 32'h40, 2'b00, 1'b1, 1'b1);
        send(0, 32'h7F, 2'b11, 1'b0, 1'b1);
        wait_empty(20);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
